// File: rtl/ml_layer_seq.sv
// Layer scheduler: issues the per-layer step command sequence to the ML control FSM.
// Latency: first command one cycle after a legal start; next command one cycle after step_done.
// Backpressure: each command is held stable until cmd_ready, then step_done is awaited; no input-to-output paths.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start, abort                  begin a layer when idle / abandon the current layer
//   cfg_num_rows, cfg_num_tiles   layer geometry, latched on a legal start
//   fsm_input, cmd_valid          step command and its valid flag
//   cmd_ready, step_done          command accept and step completion from the control FSM
//   busy, done, err               layer in progress / one-cycle completion / sticky error
//   tile_idx, row_idx             current tile and row within the step
//
// Optional build macro ML_LAYER_SEQ_TIMEOUT_EN adds a per-step watchdog that
// flags err and abandons the layer when a step never completes.

module ml_layer_seq #(
    parameter int X_DIM  = 15,
    parameter int Y_DIM  = 15,
    parameter int TILE_W = 8,
    parameter int TMO_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [4:0]        cfg_num_rows,
    input  logic [TILE_W-1:0] cfg_num_tiles,
    output logic [2:0]        fsm_input,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    input  logic              step_done,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [TILE_W-1:0] tile_idx,
    output logic [4:0]        row_idx
);

    localparam logic [2:0] CMD_DEFAULT  = 3'b001;
    localparam logic [2:0] CMD_LD_WT    = 3'b010;
    localparam logic [2:0] CMD_IF_S2B   = 3'b011;
    localparam logic [2:0] CMD_IF_B2PE  = 3'b100;
    localparam logic [2:0] CMD_EXEC     = 3'b101;
    localparam logic [2:0] CMD_OF_PE2B  = 3'b110;
    localparam logic [2:0] CMD_OF_B2S   = 3'b111;

    localparam logic [4:0]        ROWS_MAX = 5'(Y_DIM);
    localparam logic [TILE_W-1:0] TILE_ONE = TILE_W'(1);

    // Reject parameter sets the fixed 5-bit row fields cannot represent.
    generate
        if (X_DIM < 1 || Y_DIM < 1 || Y_DIM > 31 || TILE_W < 1 || TMO_W < 2) begin : g_bad_params
            $error("ml_layer_seq: illegal parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_WT,
        S_IFL,
        S_IFR,
        S_EXE,
        S_OFR,
        S_OFS,
        S_FIN
    } state_t;

    state_t            state, state_nxt;
    logic              in_wait, in_wait_nxt;   // 0: ISSUE phase, 1: WAIT phase
    logic [4:0]        rows_q, rows_nxt;
    logic [TILE_W-1:0] tiles_q, tiles_nxt;

    logic [2:0]        fsm_nxt;
    logic              cmd_valid_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              err_nxt;
    logic [TILE_W-1:0] tile_nxt;
    logic [4:0]        row_nxt;

    logic              last_row;
    logic              last_tile;
    logic              cfg_bad;
    logic              kill;

`ifdef ML_LAYER_SEQ_TIMEOUT_EN
    logic [TMO_W-1:0]  tmo_cnt, tmo_nxt;
    logic              tmo_hit;
`endif

    assign last_row  = (row_idx == rows_q - 5'd1);
    assign last_tile = (tile_idx == tiles_q - TILE_ONE);
    assign cfg_bad   = (cfg_num_rows == 5'd0) || (cfg_num_rows > ROWS_MAX) ||
                       (cfg_num_tiles == '0);

    function automatic logic [2:0] cmd_of(input state_t s);
        case (s)
            S_WT:    return CMD_LD_WT;
            S_IFL:   return CMD_IF_S2B;
            S_IFR:   return CMD_IF_B2PE;
            S_EXE:   return CMD_EXEC;
            S_OFR:   return CMD_OF_PE2B;
            S_OFS:   return CMD_OF_B2S;
            default: return CMD_DEFAULT;
        endcase
    endfunction

    always_comb begin
        state_nxt   = state;
        in_wait_nxt = in_wait;
        rows_nxt    = rows_q;
        tiles_nxt   = tiles_q;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        err_nxt     = err;
        tile_nxt    = tile_idx;
        row_nxt     = row_idx;
        kill        = abort;
`ifdef ML_LAYER_SEQ_TIMEOUT_EN
        tmo_nxt     = '0;
        tmo_hit     = 1'b0;
`endif

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        err_nxt = 1'b1;
                    end else begin
                        rows_nxt    = cfg_num_rows;
                        tiles_nxt   = cfg_num_tiles;
                        err_nxt     = 1'b0;
                        busy_nxt    = 1'b1;
                        tile_nxt    = '0;
                        row_nxt     = '0;
                        state_nxt   = S_WT;
                        in_wait_nxt = 1'b0;
                    end
                end
            end

            S_FIN: begin
                state_nxt = S_IDLE;
            end

            default: begin
                if (!in_wait) begin
                    // step_done is deliberately not looked at while issuing.
                    if (cmd_valid && cmd_ready) begin
                        in_wait_nxt = 1'b1;
                    end
                end else if (step_done) begin
                    in_wait_nxt = 1'b0;
                    case (state)
                        S_WT: begin
                            state_nxt = S_IFL;
                        end
                        S_IFL: begin
                            state_nxt = S_IFR;
                            row_nxt   = '0;
                        end
                        S_IFR: begin
                            if (last_row) begin
                                state_nxt = S_EXE;
                                row_nxt   = '0;
                            end else begin
                                row_nxt = row_idx + 5'd1;
                            end
                        end
                        S_EXE: begin
                            state_nxt = S_OFR;
                            row_nxt   = '0;
                        end
                        S_OFR: begin
                            if (last_row) begin
                                state_nxt = S_OFS;
                                row_nxt   = '0;
                            end else begin
                                row_nxt = row_idx + 5'd1;
                            end
                        end
                        S_OFS: begin
                            if (last_tile) begin
                                // Completion is flagged while entering FIN so done and
                                // busy=0 appear together in the FIN cycle.
                                state_nxt = S_FIN;
                                busy_nxt  = 1'b0;
                                done_nxt  = 1'b1;
                                tile_nxt  = '0;
                                row_nxt   = '0;
                            end else begin
                                // Weights stay resident; the next tile restarts at IF load.
                                state_nxt = S_IFL;
                                tile_nxt  = tile_idx + TILE_ONE;
                            end
                        end
                        default: begin
                            state_nxt = S_IDLE;
                        end
                    endcase
                end
`ifdef ML_LAYER_SEQ_TIMEOUT_EN
                else if (tmo_cnt == '1) begin
                    tmo_hit = 1'b1;
                end else begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
`endif
            end
        endcase

`ifdef ML_LAYER_SEQ_TIMEOUT_EN
        kill = abort | tmo_hit;
`endif

        if (kill) begin
            state_nxt   = S_IDLE;
            in_wait_nxt = 1'b0;
            busy_nxt    = 1'b0;
            done_nxt    = 1'b0;
            tile_nxt    = '0;
            row_nxt     = '0;
`ifdef ML_LAYER_SEQ_TIMEOUT_EN
            tmo_nxt     = '0;
`endif
        end

        // Abort beats a same-cycle start, so it also cancels that start's config verdict.
        if (abort) begin
            err_nxt = err;
        end

`ifdef ML_LAYER_SEQ_TIMEOUT_EN
        if (tmo_hit) begin
            err_nxt = 1'b1;
        end
`endif

        // Command outputs are derived from the upcoming state so they leave a register.
        cmd_valid_nxt = (state_nxt != S_IDLE) && (state_nxt != S_FIN) && !in_wait_nxt;
        fsm_nxt       = cmd_valid_nxt ? cmd_of(state_nxt) : CMD_DEFAULT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            in_wait   <= 1'b0;
            rows_q    <= 5'd0;
            tiles_q   <= '0;
            fsm_input <= CMD_DEFAULT;
            cmd_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            tile_idx  <= '0;
            row_idx   <= 5'd0;
        end else begin
            state     <= state_nxt;
            in_wait   <= in_wait_nxt;
            rows_q    <= rows_nxt;
            tiles_q   <= tiles_nxt;
            fsm_input <= fsm_nxt;
            cmd_valid <= cmd_valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            tile_idx  <= tile_nxt;
            row_idx   <= row_nxt;
        end
    end

`ifdef ML_LAYER_SEQ_TIMEOUT_EN
    // Counts WAIT cycles of the current step; zero everywhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_ml_layer_seq.sv
// Bench for ml_layer_seq: command-list reference model plus randomized responder.
// Latency: outputs compared every cycle at the falling edge against the model.
// Backpressure: cmd_ready is toggled directly and randomly; step_done delays are random.

`timescale 1ns/1ps

module tb_ml_layer_seq;

    localparam int TILE_W = 8;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [4:0]        cfg_num_rows;
    logic [TILE_W-1:0] cfg_num_tiles;
    logic [2:0]        fsm_input;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              step_done;
    logic              busy;
    logic              done;
    logic              err;
    logic [TILE_W-1:0] tile_idx;
    logic [4:0]        row_idx;

    ml_layer_seq dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .cfg_num_rows  (cfg_num_rows),
        .cfg_num_tiles (cfg_num_tiles),
        .fsm_input     (fsm_input),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .step_done     (step_done),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .tile_idx      (tile_idx),
        .row_idx       (row_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [2:0]        code;
        logic [TILE_W-1:0] tile;
        logic [4:0]        row;
    } cmd_t;

    typedef enum int {M_IDLE, M_ISSUE, M_WAIT, M_DONE} mphase_t;

    cmd_t    m_q[$];     // commands still to be accepted in this layer
    cmd_t    m_cur;      // command whose step is in progress
    mphase_t m_phase;
    logic    m_err;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cmd_t mk(input logic [2:0] code, input int t, input int r);
        cmd_t c;
        c.code = code;
        c.tile = TILE_W'(t);
        c.row  = 5'(r);
        return c;
    endfunction

    // One layer = weights once, then per tile: IF load, rows x IF->PE, exec, rows x OF->buf, OF store.
    task automatic build_layer(input int rows, input int tiles);
        m_q.delete();
        m_q.push_back(mk(3'b010, 0, 0));
        for (int t = 0; t < tiles; t++) begin
            m_q.push_back(mk(3'b011, t, 0));
            for (int r = 0; r < rows; r++) m_q.push_back(mk(3'b100, t, r));
            m_q.push_back(mk(3'b101, t, 0));
            for (int r = 0; r < rows; r++) m_q.push_back(mk(3'b110, t, r));
            m_q.push_back(mk(3'b111, t, 0));
        end
    endtask

    initial begin
        m_phase = M_IDLE;
        m_err   = 1'b0;
        m_cur   = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_phase = M_IDLE;
                m_err   = 1'b0;
                m_cur   = '0;
                m_q.delete();
            end else if (abort) begin
                m_phase = M_IDLE;
                m_q.delete();
            end else begin
                case (m_phase)
                    M_IDLE: begin
                        if (start) begin
                            if (cfg_num_rows == 5'd0 || cfg_num_rows > 5'd15 || cfg_num_tiles == '0) begin
                                m_err = 1'b1;
                            end else begin
                                m_err = 1'b0;
                                build_layer(int'(cfg_num_rows), int'(cfg_num_tiles));
                                m_phase = M_ISSUE;
                            end
                        end
                    end
                    M_ISSUE: begin
                        if (cmd_ready) begin
                            m_cur = m_q.pop_front();
                            m_phase = M_WAIT;
                        end
                    end
                    M_WAIT: begin
                        if (step_done) m_phase = (m_q.size() == 0) ? M_DONE : M_ISSUE;
                    end
                    default: m_phase = M_IDLE;
                endcase
            end
        end
    end

    // ---------------- observation / compare ----------------
    logic [2:0]        seen_code[$];
    logic [TILE_W-1:0] seen_tile[$];
    int n_done;
    int n_row1_issue;

    initial begin
        n_done = 0;
        n_row1_issue = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("cmd_valid", 32'(cmd_valid), 32'(m_phase == M_ISSUE));
                chk("fsm_input", 32'(fsm_input),
                    (m_phase == M_ISSUE) ? 32'(m_q[0].code) : 32'd1);
                chk("busy", 32'(busy), 32'(m_phase == M_ISSUE || m_phase == M_WAIT));
                chk("done", 32'(done), 32'(m_phase == M_DONE));
                chk("err", 32'(err), 32'(m_err));
                chk("tile_idx", 32'(tile_idx),
                    (m_phase == M_ISSUE) ? 32'(m_q[0].tile) :
                    (m_phase == M_WAIT)  ? 32'(m_cur.tile)  : 32'd0);
                chk("row_idx", 32'(row_idx),
                    (m_phase == M_ISSUE) ? 32'(m_q[0].row) :
                    (m_phase == M_WAIT)  ? 32'(m_cur.row)  : 32'd0);
                if (cmd_valid && cmd_ready) begin
                    seen_code.push_back(fsm_input);
                    seen_tile.push_back(tile_idx);
                end
                if (done) n_done++;
                if (cmd_valid && fsm_input == 3'b100 && row_idx == 5'd1) n_row1_issue++;
            end
        end
    end

    // ---------------- control-FSM responder ----------------
    bit rnd_mode;
    bit hold_row1;
    bit held;

    initial begin
        int cd;
        int hold_cnt;
        bit hs;
        cmd_ready = 1'b0;
        step_done = 1'b0;
        cd = -1;
        hold_cnt = 0;
        forever begin
            @(posedge clk);
            hs = cmd_valid && cmd_ready;
            #1;
            if (hs) cd = rnd_mode ? int'($urandom_range(0, 5)) : 2;
            else if (cd > 0) cd--;
            step_done = (cd == 0);
            if (cd == 0) cd = -1;
            if (rnd_mode && $urandom_range(0, 9) == 0) step_done = 1'b1;  // stray pulses
            if (hold_row1 && !held && cmd_valid && fsm_input == 3'b100 && row_idx == 5'd1) begin
                held = 1'b1;
                hold_cnt = 5;
            end
            if (hold_cnt > 0) begin
                cmd_ready = 1'b0;
                hold_cnt--;
            end else begin
                cmd_ready = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic clear_obs();
        seen_code.delete();
        seen_tile.delete();
        n_done = 0;
        n_row1_issue = 0;
        held = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_layer(input int rows, input int tiles, input bit rmode,
                             input bit abort_exe, input bit mid_start);
        bit finished;
        bit aborted;
        clear_obs();
        rnd_mode = rmode;
        cfg_num_rows = 5'(rows);
        cfg_num_tiles = TILE_W'(tiles);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cfg_num_rows = 5'($urandom);       // latched copy must be used from here on
        cfg_num_tiles = TILE_W'($urandom);
        finished = 1'b0;
        aborted = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            start = (mid_start && c == 7 && (m_phase == M_ISSUE || m_phase == M_WAIT));
            if (abort_exe && !aborted && m_phase == M_WAIT && m_cur.code == 3'b101) begin
                abort = 1'b1;
                aborted = 1'b1;
            end else begin
                abort = 1'b0;
            end
            if (m_phase == M_IDLE) begin
                finished = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
        chk("layer_completes", 32'(finished), 32'd1);
    endtask

    task automatic bad_start(input logic [4:0] r, input logic [TILE_W-1:0] t);
        cfg_num_rows = r;
        cfg_num_tiles = t;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("bad_cfg_err", 32'(err), 32'd1);
        chk("bad_cfg_busy", 32'(busy), 32'd0);
        chk("bad_cfg_valid", 32'(cmd_valid), 32'd0);
        idle_cycles(2);
        chk("bad_cfg_stays_idle", 32'(busy | cmd_valid), 32'd0);
    endtask

    initial begin
        logic [2:0] exp1 [8];
        int n_wt;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        cfg_num_rows = 5'd0;
        cfg_num_tiles = '0;
        rnd_mode = 1'b0;
        hold_row1 = 1'b0;
        held = 1'b0;
        exp1 = '{3'b010, 3'b011, 3'b100, 3'b100, 3'b101, 3'b110, 3'b110, 3'b111};

        idle_cycles(3);
        chk("rst_fsm_input", 32'(fsm_input), 32'd1);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_idx", 32'({tile_idx, row_idx}), 32'd0);
        rst = 1'b0;
        idle_cycles(3);

        // rows=2, tiles=1, ready tied high, step_done 3 cycles after each handshake
        run_layer(2, 1, 1'b0, 1'b0, 1'b0);
        chk("t1_cmd_count", 32'(seen_code.size()), 32'd8);
        for (int i = 0; i < 8 && i < seen_code.size(); i++)
            chk("t1_cmd_seq", 32'(seen_code[i]), 32'(exp1[i]));
        chk("t1_done_pulses", 32'(n_done), 32'd1);
        idle_cycles(6);

        // rows=1, tiles=3 with a start pulse while busy
        run_layer(1, 3, 1'b0, 1'b0, 1'b1);
        chk("t2_cmd_count", 32'(seen_code.size()), 32'd16);
        n_wt = 0;
        foreach (seen_code[i]) if (seen_code[i] == 3'b010) n_wt++;
        chk("t2_wt_once", 32'(n_wt), 32'd1);
        begin
            int k;
            k = 0;
            foreach (seen_code[i]) begin
                if (seen_code[i] == 3'b011) begin
                    chk("t2_tile_at_ifl", 32'(seen_tile[i]), 32'(k));
                    k++;
                end
            end
            chk("t2_ifl_count", 32'(k), 32'd3);
        end
        chk("t2_done_pulses", 32'(n_done), 32'd1);
        idle_cycles(6);

        // cmd_ready held low 5 cycles at IFR row 1: six issue cycles in total
        hold_row1 = 1'b1;
        run_layer(2, 1, 1'b0, 1'b0, 1'b0);
        hold_row1 = 1'b0;
        chk("t3_row1_issue_cycles", 32'(n_row1_issue), 32'd6);
        chk("t3_cmd_count", 32'(seen_code.size()), 32'd8);
        idle_cycles(6);

        // bad configurations, then a legal start clears err
        chk("t4_err_before", 32'(err), 32'd0);
        bad_start(5'd0, TILE_W'(1));
        bad_start(5'd16, TILE_W'(1));
        bad_start(5'd3, TILE_W'(0));
        run_layer(3, 2, 1'b0, 1'b0, 1'b0);
        chk("t4_err_cleared", 32'(err), 32'd0);
        chk("t4_cmd_count", 32'(seen_code.size()), 32'd19);
        idle_cycles(6);

        // abort during the EXE wait: back to idle, no done
        run_layer(2, 2, 1'b0, 1'b1, 1'b0);
        chk("t5_no_done", 32'(n_done), 32'd0);
        chk("t5_fsm_default", 32'(fsm_input), 32'd1);
        chk("t5_idle", 32'(busy | cmd_valid), 32'd0);
        idle_cycles(6);

        // randomized layers with random backpressure, stray step_done, aborts, bad configs
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 3) == 0)
                bad_start(5'($urandom_range(16, 31)), TILE_W'($urandom_range(1, 4)));
            run_layer($urandom_range(1, 15), $urandom_range(1, 4), 1'b1,
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
            rnd_mode = 1'b0;
            idle_cycles(8);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
